// File: rtl/sc_io_pkg.sv
// sc_io_pkg: shared constants, FSM encodings and segment codes for the sc_io_port block
package sc_io_pkg;

    // Default base address of register 0
    localparam logic [31:0] IO_BASE_DEF = 32'h0000_00C0;

    // Register offsets (word index taken from addr[4:2])
    localparam logic [2:0] OFF_SW_A   = 3'd0;
    localparam logic [2:0] OFF_SW_B   = 3'd1;
    localparam logic [2:0] OFF_RESULT = 3'd2;
    localparam logic [2:0] OFF_LED    = 3'd3;
    localparam logic [2:0] OFF_STATUS = 3'd4;

    // Conversion engine states
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_STORE = 2'd2
    } bcd_state_e;

    // Display channels, visited round-robin
    typedef enum logic [1:0] {
        CH_A = 2'd0,
        CH_B = 2'd1,
        CH_T = 2'd2
    } chan_e;

    // Active-low segment patterns {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    // Decimal digit to segment pattern; non-decimal codes show a dash
    function automatic logic [6:0] seg7(input logic [3:0] d);
        return d == 4'd0 ? SEG_0 :
               d == 4'd1 ? SEG_1 :
               d == 4'd2 ? SEG_2 :
               d == 4'd3 ? SEG_3 :
               d == 4'd4 ? SEG_4 :
               d == 4'd5 ? SEG_5 :
               d == 4'd6 ? SEG_6 :
               d == 4'd7 ? SEG_7 :
               d == 4'd8 ? SEG_8 :
               d == 4'd9 ? SEG_9 : SEG_DASH;
    endfunction

endpackage

// File: rtl/sc_bin2bcd_seq.sv
// sc_bin2bcd_seq: sequential 8-bit binary to BCD converter (double-dabble), LOAD -> SHIFT x8 -> STORE
module sc_bin2bcd_seq
    import sc_io_pkg::*;
(
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [7:0] value_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o,
    output logic       ovf_o
);

    bcd_state_e  state_q;
    logic [2:0]  cnt_q;
    logic [7:0]  bin_q;
    logic [11:0] bcd_q;
    logic [11:0] adj_d;
    logic        done_q;

    // Add 3 to every BCD nibble that is 5 or more before the next shift
    always_comb begin
        adj_d[3:0]  = bcd_q[3:0]  >= 4'd5 ? bcd_q[3:0]  + 4'd3 : bcd_q[3:0];
        adj_d[7:4]  = bcd_q[7:4]  >= 4'd5 ? bcd_q[7:4]  + 4'd3 : bcd_q[7:4];
        adj_d[11:8] = bcd_q[11:8] >= 4'd5 ? bcd_q[11:8] + 4'd3 : bcd_q[11:8];
    end

    // Conversion FSM; done is high exactly during the STORE cycle
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_LOAD: begin
                    if (start_i) begin
                        bin_q   <= value_i;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    {bcd_q, bin_q} <= {adj_d, bin_q} << 1;
                    cnt_q          <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_q <= ST_STORE;
                        done_q  <= 1'b1;
                    end
                end
                ST_STORE: state_q <= ST_LOAD;
                default:  state_q <= ST_LOAD;
            endcase
        end
    end

    assign busy_o = start_i | (state_q != ST_LOAD);
    assign done_o = done_q;
    assign tens_o = bcd_q[7:4];
    assign ones_o = bcd_q[3:0];
    assign ovf_o  = |bcd_q[11:8];

endmodule

// File: rtl/sc_io_port.sv
// sc_io_port: memory-mapped switch/LED/result I/O with debounced inputs and 7-segment display refresh
module sc_io_port
    import sc_io_pkg::*;
#(
    parameter logic [31:0] IO_BASE   = IO_BASE_DEF,
    parameter int          SW_W      = 5,
    parameter int          DB_CYCLES = 4
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic [31:0]     addr_i,
    input  logic [31:0]     wdata_i,
    input  logic            we_i,
    output logic [31:0]     rdata_o,
    input  logic [SW_W-1:0] sw_a_i,
    input  logic [SW_W-1:0] sw_b_i,
    output logic [9:0]      led_o,
    output logic [6:0]      hex_a_hi_o,
    output logic [6:0]      hex_a_lo_o,
    output logic [6:0]      hex_b_hi_o,
    output logic [6:0]      hex_b_lo_o,
    output logic [6:0]      hex_t_hi_o,
    output logic [6:0]      hex_t_lo_o
);

    localparam int             CW     = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]  DB_MAX = CW'(DB_CYCLES);

    logic              hit;
    logic [2:0]        off;
    logic              wr;
    logic [7:0]        result_q, result_d;
    logic [9:0]        led_q, led_d;

    // Index 0 is operand A, index 1 is operand B
    logic [1:0][SW_W-1:0] raw;
    logic [1:0][SW_W-1:0] s1_q, s2_q, last_q, db_q;
    logic [1:0][CW-1:0]   cnt_q, cnt_d;

    chan_e             ch_q, ch_d;
    logic [7:0]        value;
    logic              busy, done, ovf;
    logic [3:0]        tens, ones;
    logic [13:0]       pair_d;
    logic [2:0][13:0]  disp_q;

    logic              unused_ok;

    assign hit       = addr_i[31:5] == IO_BASE[31:5];
    assign off       = addr_i[4:2];
    assign wr        = we_i & hit;
    assign raw       = {sw_b_i, sw_a_i};
    assign unused_ok = ^{addr_i[1:0], wdata_i[31:10]};

    // Next values of the CPU-writable registers
    always_comb begin
        result_d = (wr && off == OFF_RESULT) ? wdata_i[7:0] : result_q;
        led_d    = (wr && off == OFF_LED)    ? wdata_i[9:0] : led_q;
    end

    // CPU-writable registers; reset wins over a same-cycle write
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            result_q <= '0;
            led_q    <= '0;
        end else begin
            result_q <= result_d;
            led_q    <= led_d;
        end
    end

    // Read mux; anything outside the window or unmapped reads zero
    always_comb begin
        rdata_o = !hit                ? 32'd0 :
                  off == OFF_SW_A     ? 32'(db_q[0]) :
                  off == OFF_SW_B     ? 32'(db_q[1]) :
                  off == OFF_RESULT   ? 32'(result_q) :
                  off == OFF_LED      ? 32'(led_q) :
                  off == OFF_STATUS   ? 32'(busy) : 32'd0;
    end

    // Run length of equal synced samples, counting the current one; saturates at DB_CYCLES
    always_comb begin
        for (int i = 0; i < 2; i++)
            cnt_d[i] = (s2_q[i] != last_q[i]) ? CW'(1) :
                       (cnt_q[i] == DB_MAX)   ? cnt_q[i] : cnt_q[i] + 1'b1;
    end

    // Two-flop synchronizers and debouncers; accept a value once it has been stable DB_CYCLES samples
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            s1_q   <= '0;
            s2_q   <= '0;
            last_q <= '0;
            cnt_q  <= '0;
            db_q   <= '0;
        end else begin
            s1_q   <= raw;
            s2_q   <= s1_q;
            last_q <= s2_q;
            cnt_q  <= cnt_d;
            for (int i = 0; i < 2; i++)
                if (cnt_d[i] >= DB_MAX)
                    db_q[i] <= s2_q[i];
        end
    end

    // Channel value presented to the converter and the digit pair it produced
    always_comb begin
        value  = ch_q == CH_A ? 8'(db_q[0]) :
                 ch_q == CH_B ? 8'(db_q[1]) : result_q;
        ch_d   = ch_q == CH_A ? CH_B :
                 ch_q == CH_B ? CH_T : CH_A;
        pair_d = ovf ? {SEG_DASH, SEG_DASH} : {seg7(tens), seg7(ones)};
    end

    sc_bin2bcd_seq u_bcd (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .start_i (1'b1),
        .value_i (value),
        .busy_o  (busy),
        .done_o  (done),
        .tens_o  (tens),
        .ones_o  (ones),
        .ovf_o   (ovf)
    );

    // Store the finished digit pair into the current channel and move round-robin to the next
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ch_q   <= CH_A;
            disp_q <= {3{SEG_0, SEG_0}};
        end else if (done) begin
            ch_q         <= ch_d;
            disp_q[ch_q] <= pair_d;
        end
    end

    assign led_o      = led_q;
    assign hex_a_hi_o = disp_q[0][13:7];
    assign hex_a_lo_o = disp_q[0][6:0];
    assign hex_b_hi_o = disp_q[1][13:7];
    assign hex_b_lo_o = disp_q[1][6:0];
    assign hex_t_hi_o = disp_q[2][13:7];
    assign hex_t_lo_o = disp_q[2][6:0];

endmodule
